draw_text_box: RTL
==================

Name: draw_text_box

Overview:
- Pixel-pipeline stage that renders a 16x16-character text box onto the VGA stream.
- It drives the character position to a text ROM (char_xy -> char_code) and the glyph address to a font ROM (font_addr -> font_line).
- It overlays glyph pixels on the incoming RGB.
- Sits in the draw chain between background/board drawing and the VGA output register. It is the reader side of the text-ROM interface used by the menu and settings screens.

Parameters:
- X_POS, 0: left edge of the box in pixels, 11-bit range.
- Y_POS, 0: top edge of the box in pixels, 11-bit range.
- TEXT_COLOR, 12'hFFF: RGB444 colour of set glyph pixels.
- BG_COLOR, 12'h000: RGB444 colour of clear glyph pixels inside the box when FILL_BG=1.
- FILL_BG, 0: 1 = clear glyph pixels inside the box take BG_COLOR; 0 = they pass input rgb.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream pixel colour
- char_xy  out  8  {row[3:0], col[3:0]} to text ROM; combinational from current inputs
- char_code  in  7  text ROM data; valid 1 clk after char_xy
- font_addr  out  11  {char_code, glyph_line[3:0]} to font ROM; combinational from char_code and delayed line
- font_line  in  8  font ROM row; valid 1 clk after font_addr; bit 7 = leftmost pixel
- hcount_out, vcount_out  out  11  inputs delayed 3 clk
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  inputs delayed 3 clk
- rgb_out  out  12  composited pixel

Behaviour:
- Reset: every output register and pipeline register clears to 0, including rgb_out, all timing outputs and the blink state. char_xy and font_addr follow their combinational inputs.
- Box geometry:
  - rel_x = hcount_in - X_POS, rel_y = vcount_in - Y_POS, both 11-bit unsigned.
  - in_box = (hcount_in >= X_POS) && (hcount_in < X_POS+128) && (vcount_in >= Y_POS) && (vcount_in < Y_POS+256).
- Character addressing:
  - char_xy = {rel_y[7:4], rel_x[6:3]}.
  - glyph_line = rel_y[3:0].
  - pix_col = rel_x[2:0].
  - Outside the box, char_xy is don't-care; the value is still driven and later masked.
- Pipeline timing (cycle 0 = inputs sampled):
  - Stage 1 registers glyph_line, pix_col, in_box and all timing signals plus rgb_in. char_code is valid in this stage.
  - Stage 2 registers pix_col, in_box, timing and rgb again. font_line is valid in this stage.
  - Stage 3 is the output register.
  - Total latency is exactly 3 clk for every output. No bubbles, one pixel per clk.
- Compositing at stage 3, in priority order:
  1. If delayed hblnk or vblnk is set: rgb_out = delayed rgb_in.
  2. Else if in_box and font_line[7 - pix_col] is 1: rgb_out = TEXT_COLOR.
  3. Else if in_box and FILL_BG is 1: rgb_out = BG_COLOR.
  4. Else: rgb_out = delayed rgb_in.
- Boundaries:
  - X_POS+128 or Y_POS+256 beyond the visible area: the box is clipped naturally and nothing wraps, because the comparison is done in 11 bits with a 12-bit sum.
  - hcount wrap to 0 mid-pipeline: unaffected, since each pixel carries its own delayed state.
  - Reset asserted mid-frame: the pipeline flushes to 0 for the cycle(s) rst is high, and rendering resumes 3 clk after rst deasserts.
- Undefined/space glyphs: the font ROM returns all-zero rows, so the result is background or passthrough.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- When defined:
  - A 6-bit frame counter increments on each rising edge of vsync_in, i.e. vsync_in high and its previous-cycle value low. It wraps 63 -> 0.
  - Glyph pixels are drawn only while counter[5] = 0, so text is visible for 32 frames and hidden for 32.
  - Hidden glyph pixels are treated as clear: BG_COLOR or passthrough, per FILL_BG.
  - The counter and the edge-detect register reset to 0.
- When undefined: no counter exists and glyphs are always visible.

Test Plan:
- Reset: hold rst 2 clk with random inputs -> all outputs 0. Release -> the first valid output appears 3 clk after the first post-reset input.
- Latency: drive hcount 0..799 and vcount 0..524 with the box at X_POS=64, Y_POS=32 -> hcount_out, vcount_out, syncs and blanks equal inputs delayed exactly 3 clk throughout the frame.
- Addressing: hcount=64+24, vcount=32+5 -> char_xy=8'h03. With the text model returning 'u' and a font model keyed on {7'h75,4'd5} -> font_addr=11'h755 one clk later.
- Pixel select:
  - font model returns 8'b1000_0001 for that row.
  - hcount 88..95 -> rgb_out = TEXT_COLOR at pixel offsets 0 and 7, rgb_in elsewhere (FILL_BG=0).
  - Rerun with FILL_BG=1 and BG_COLOR=12'h00F -> 12'h00F at offsets 1..6.
- Clip/blank:
  - hcount=63 or 192, or vcount=288 -> rgb_out = rgb_in, with the font model returning 8'hFF.
  - Inside the box with hblnk_in=1 -> rgb_out = rgb_in.
- Blink (TEXT_BLINK_EN):
  - 32 vsync pulses -> glyph pixels suppressed.
  - 32 more -> visible again.
  - Holding vsync high for multiple clk counts only one edge.

Source files
------------

// File: rtl/draw_text_box.sv
// -----------------------------------------------------------------------------
// draw_text_box
//
// Pixel-pipeline stage that renders a 16x16-character text box (128x256 pixels,
// 8x16 glyphs) onto the VGA stream. The current pixel position is translated
// into a character cell address for an external text ROM. The returned
// character code, combined with the glyph line, addresses an external font
// ROM. The selected font bit is then composited over the incoming colour.
//
// Both ROMs are synchronous: data returns one clock after the address.
// Every output is delayed exactly 3 clocks from the inputs, and the pipeline
// accepts one pixel per clock.
//
// Optional build macro: TEXT_BLINK_EN
//   When this macro is defined, a 6-bit frame counter advances on each rising
//   edge of vsync_in. Glyph pixels are shown only while counter[5] is 0.
//
// Parameters:
//   X_POS, Y_POS  top-left corner of the box in pixels (11-bit)
//   TEXT_COLOR    RGB444 colour of set glyph pixels
//   BG_COLOR      RGB444 colour of clear glyph pixels when FILL_BG = 1
//   FILL_BG       1: clear glyph pixels inside the box take BG_COLOR
//                 0: clear glyph pixels pass rgb_in through
//
// Ports:
//   clk, rst                      pixel clock, synchronous active-high reset
//   hcount_in, vcount_in          pixel position (11 bits each)
//   hsync/hblnk/vsync/vblnk_in    timing signals
//   rgb_in                        upstream pixel colour (RGB444)
//   char_xy    -> text ROM        {row[3:0], col[3:0]}, combinational
//   char_code  <- text ROM        valid one clock after char_xy
//   font_addr  -> font ROM        {char_code, glyph_line[3:0]}, combinational
//   font_line  <- font ROM        valid one clock after font_addr; bit 7 = left
//   *_out                         timing delayed 3 clocks
//   rgb_out                       composited pixel colour
// -----------------------------------------------------------------------------
module draw_text_box #(
  parameter logic [10:0] X_POS      = 11'd0,
  parameter logic [10:0] Y_POS      = 11'd0,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter bit          FILL_BG    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  // The end coordinates use 12 bits so that a box near the edge of the
  // 11-bit range is clipped and does not wrap around to 0.
  localparam logic [11:0] X_END = {1'b0, X_POS} + 12'd128;
  localparam logic [11:0] Y_END = {1'b0, Y_POS} + 12'd256;

  // ---------------------------------------------------------------------------
  // Stage 0: geometry and the text ROM address
  // ---------------------------------------------------------------------------
  // Only the low bits of the offsets are used. The low bits of a difference
  // depend only on the low bits of the operands, so narrower subtractions
  // give the same result.
  logic [6:0] w_rel_x;
  logic [7:0] w_rel_y;
  logic       w_in_box;
  timing_t    w_tim_in;

  assign w_rel_x  = hcount_in[6:0] - X_POS[6:0];
  assign w_rel_y  = vcount_in[7:0] - Y_POS[7:0];
  assign w_in_box = (hcount_in >= X_POS) && ({1'b0, hcount_in} < X_END) &&
                    (vcount_in >= Y_POS) && ({1'b0, vcount_in} < Y_END);
  assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, hblnk: hblnk_in,
                      vsync: vsync_in, vblnk: vblnk_in};

  // Outside the box this address is meaningless. The result is masked
  // later by in_box.
  assign char_xy = {w_rel_y[7:4], w_rel_x[6:3]};

  // ---------------------------------------------------------------------------
  // Stage 1: char_code is valid. Form the font ROM address.
  // ---------------------------------------------------------------------------
  timing_t     r1_tim;
  logic [11:0] r1_rgb;
  logic [3:0]  r1_line;
  logic [2:0]  r1_col;
  logic        r1_in_box;

  // NOTE: clocked state uses non-blocking (<=) assignments so that every
  // stage samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_tim    <= '0;
      r1_rgb    <= '0;
      r1_line   <= '0;
      r1_col    <= '0;
      r1_in_box <= 1'b0;
    end else begin
      r1_tim    <= w_tim_in;
      r1_rgb    <= rgb_in;
      r1_line   <= w_rel_y[3:0];
      r1_col    <= w_rel_x[2:0];
      r1_in_box <= w_in_box;
    end
  end

  assign font_addr = {char_code, r1_line};

  // ---------------------------------------------------------------------------
  // Stage 2: font_line is valid. Select the pixel and composite.
  // ---------------------------------------------------------------------------
  timing_t     r2_tim;
  logic [11:0] r2_rgb;
  logic [2:0]  r2_col;
  logic        r2_in_box;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_tim    <= '0;
      r2_rgb    <= '0;
      r2_col    <= '0;
      r2_in_box <= 1'b0;
    end else begin
      r2_tim    <= r1_tim;
      r2_rgb    <= r1_rgb;
      r2_col    <= r1_col;
      r2_in_box <= r1_in_box;
    end
  end

  logic w_glyph_visible;

`ifdef TEXT_BLINK_EN
  // The frame counter advances once per vsync rising edge. Holding vsync
  // high for several clocks still counts as a single frame.
  logic       r_vsync_prev;
  logic [5:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (vsync_in && !r_vsync_prev) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  assign w_glyph_visible = ~r_frame_cnt[5];
`else
  assign w_glyph_visible = 1'b1;
`endif

  logic        w_pix_set;
  logic [11:0] w_rgb_next;

  // NOTE: every signal written in always_comb receives a default value
  // first. Otherwise a path that leaves the signal unassigned would infer
  // a latch.
  always_comb begin
    w_pix_set  = font_line[3'd7 - r2_col] && w_glyph_visible;
    w_rgb_next = r2_rgb;
    if (r2_tim.hblnk || r2_tim.vblnk) begin
      w_rgb_next = r2_rgb;
    end else if (r2_in_box && w_pix_set) begin
      w_rgb_next = TEXT_COLOR;
    end else if (r2_in_box && FILL_BG) begin
      w_rgb_next = BG_COLOR;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output register
  // ---------------------------------------------------------------------------
  timing_t     r3_tim;
  logic [11:0] r_rgb_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_tim    <= '0;
      r_rgb_out <= '0;
    end else begin
      r3_tim    <= r2_tim;
      r_rgb_out <= w_rgb_next;
    end
  end

  assign hcount_out = r3_tim.hcount;
  assign vcount_out = r3_tim.vcount;
  assign hsync_out  = r3_tim.hsync;
  assign hblnk_out  = r3_tim.hblnk;
  assign vsync_out  = r3_tim.vsync;
  assign vblnk_out  = r3_tim.vblnk;
  assign rgb_out    = r_rgb_out;

endmodule
